// File: rtl/gcd_arb_pkg.sv
// Shared types and defaults for the round-robin GCD arbiter and its engine.
package gcd_arb_pkg;

   // Arbiter FSM: pick a requester, short-circuit or start the engine,
   // wait for it, then present the response for one cycle.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      RESP = 2'd3
   } gcd_state_e;

   localparam int unsigned NREQ_DEF    = 4;
   localparam int unsigned DW_DEF      = 32;
   localparam int unsigned TIMEOUT_DEF = 4096;

   // Width of a requester index; never narrower than one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned ID_W = id_width(NREQ_DEF);

endpackage

// File: rtl/gcd_arbiter_engine.sv
// gcd_engine: iterative subtract-only GCD datapath shared by all requesters.
// eng_start loads the operands; every following cycle the larger operand is
// reduced by the smaller until both match, then eng_done pulses for one cycle
// with eng_result holding the common value. eng_clear abandons any job.
module gcd_engine
   import gcd_arb_pkg::*;
#(
   parameter int unsigned DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          eng_start,
   input  logic [DW-1:0] eng_a,
   input  logic [DW-1:0] eng_b,
   input  logic          eng_clear,
   output logic          eng_done,
   output logic [DW-1:0] eng_result
);

   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [DW-1:0] result_q, result_d;
   logic          run_q, run_d;
   logic          done_q, done_d;

   // Next-state: clear beats start beats iteration; always subtract smaller from larger.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      run_d    = run_q;
      done_d   = 1'b0;
      if (eng_clear) begin
         a_d      = '0;
         b_d      = '0;
         result_d = '0;
         run_d    = 1'b0;
      end else if (eng_start) begin
         a_d   = eng_a;
         b_d   = eng_b;
         run_d = 1'b1;
      end else if (run_q) begin
         if (a_q > b_q) begin
            a_d = a_q - b_q;
         end else if (b_q > a_q) begin
            b_d = b_q - a_q;
         end else begin
            done_d   = 1'b1;
            result_d = a_q;
            run_d    = 1'b0;
         end
      end
   end

   // Engine registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         run_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         run_q    <= run_d;
         done_q   <= done_d;
      end
   end

   assign eng_done   = done_q;
   assign eng_result = result_q;

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin scheduler sharing one gcd_engine among NREQ
// requesters. Grants in IDLE, acks the winner, short-circuits zero operands,
// otherwise runs the engine and returns the result tagged with the winner id.
// Optional watchdog on the RUN state: define GCD_ARB_WATCHDOG_EN.
module gcd_arbiter
   import gcd_arb_pkg::*;
#(
   parameter  int unsigned NREQ           = NREQ_DEF,
   parameter  int unsigned DW             = DW_DEF,
   parameter  int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF,
   localparam int unsigned IDW            = id_width(NREQ)
) (
   input  logic               csi_clk,
   input  logic               rsi_reset_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_a,
   input  logic [NREQ*DW-1:0] req_b,
   output logic [NREQ-1:0]    ack,
   output logic               resp_valid,
   output logic [IDW-1:0]     resp_id,
   output logic [DW-1:0]      resp_result,
   output logic               resp_err,
   output logic               busy
);

   if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
      $error("gcd_arbiter: NREQ must be in 2..16");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("gcd_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   gcd_state_e        state_q, state_d;
   logic [DW-1:0]     a_q, a_d;
   logic [DW-1:0]     b_q, b_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic              resp_valid_q, resp_valid_d;
   logic [IDW-1:0]    resp_id_q, resp_id_d;
   logic [DW-1:0]     resp_result_q, resp_result_d;

   logic              win_vld;
   logic [IDW-1:0]    win_id;
   int unsigned       idx;

   logic              eng_start;
   logic              eng_clear;
   logic              eng_done;
   logic [DW-1:0]     eng_result;

`ifdef GCD_ARB_WATCHDOG_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              resp_err_q, resp_err_d;
`endif

   // Round-robin search: first asserted request at or after rr_ptr, wrapping.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      idx     = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = (32'(rr_ptr_q) + i) % NREQ;
         if (!win_vld && req[idx]) begin
            win_vld = 1'b1;
            win_id  = IDW'(idx);
         end
      end
   end

   // FSM and response staging; response registers load on entry to RESP so
   // resp_valid is high exactly while the FSM sits in RESP.
   always_comb begin
      state_d       = state_q;
      a_d           = a_q;
      b_d           = b_q;
      id_d          = id_q;
      rr_ptr_d      = rr_ptr_q;
      ack_d         = '0;
      resp_valid_d  = 1'b0;
      resp_id_d     = resp_id_q;
      resp_result_d = resp_result_q;
      eng_start     = 1'b0;
      eng_clear     = 1'b0;
`ifdef GCD_ARB_WATCHDOG_EN
      cnt_d         = cnt_q;
      resp_err_d    = resp_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               a_d           = req_a[win_id*DW +: DW];
               b_d           = req_b[win_id*DW +: DW];
               id_d          = win_id;
               ack_d[win_id] = 1'b1;
               state_d       = LOAD;
            end
         end
         LOAD: begin
            if (a_q == '0 || b_q == '0) begin
               resp_valid_d  = 1'b1;
               resp_id_d     = id_q;
               resp_result_d = a_q | b_q;
`ifdef GCD_ARB_WATCHDOG_EN
               resp_err_d    = 1'b0;
`endif
               state_d       = RESP;
            end else begin
               eng_start = 1'b1;
`ifdef GCD_ARB_WATCHDOG_EN
               cnt_d     = '0;
`endif
               state_d   = RUN;
            end
         end
         RUN: begin
            if (eng_done) begin
               resp_valid_d  = 1'b1;
               resp_id_d     = id_q;
               resp_result_d = eng_result;
`ifdef GCD_ARB_WATCHDOG_EN
               resp_err_d    = 1'b0;
`endif
               state_d       = RESP;
            end
`ifdef GCD_ARB_WATCHDOG_EN
            else if (cnt_q + 1'b1 == CW'(TIMEOUT_CYCLES)) begin
               eng_clear     = 1'b1;
               resp_valid_d  = 1'b1;
               resp_id_d     = id_q;
               resp_result_d = '0;
               resp_err_d    = 1'b1;
               state_d       = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         RESP: begin
            rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Arbiter state and output registers.
   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         state_q       <= IDLE;
         a_q           <= '0;
         b_q           <= '0;
         id_q          <= '0;
         rr_ptr_q      <= '0;
         ack_q         <= '0;
         resp_valid_q  <= 1'b0;
         resp_id_q     <= '0;
         resp_result_q <= '0;
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         b_q           <= b_d;
         id_q          <= id_d;
         rr_ptr_q      <= rr_ptr_d;
         ack_q         <= ack_d;
         resp_valid_q  <= resp_valid_d;
         resp_id_q     <= resp_id_d;
         resp_result_q <= resp_result_d;
      end
   end

`ifdef GCD_ARB_WATCHDOG_EN
   // Watchdog counter and error flag.
   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         cnt_q      <= '0;
         resp_err_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         resp_err_q <= resp_err_d;
      end
   end
   assign resp_err = resp_err_q;
`else
   assign resp_err = 1'b0;
`endif

   gcd_engine #(
      .DW(DW)
   ) u_engine (
      .clk        (csi_clk),
      .rst_n      (rsi_reset_n),
      .eng_start  (eng_start),
      .eng_a      (a_q),
      .eng_b      (b_q),
      .eng_clear  (eng_clear),
      .eng_done   (eng_done),
      .eng_result (eng_result)
   );

   assign ack         = ack_q;
   assign resp_valid  = resp_valid_q;
   assign resp_id     = resp_id_q;
   assign resp_result = resp_result_q;
   assign busy        = (state_q != IDLE);

endmodule
